// File: rtl/redmule_mem_port_arbiter.sv
// Shares one memory port among the streamer channels (X, W, Y reads; Z writes).
// Round-robin with a starvation override; an in-order tag FIFO routes responses back.
module redmule_mem_port_arbiter #(
  parameter int unsigned NR        = 4,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_OUT   = 4,
  parameter int unsigned STARVE_TH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic [NR-1:0]      req_i,
  input  logic [NR*AW-1:0]   add_i,
  input  logic [NR-1:0]      wen_i,
  input  logic [NR*DW/8-1:0] be_i,
  input  logic [NR*DW-1:0]   data_i,
  output logic [NR-1:0]      gnt_o,
  output logic [NR-1:0]      r_valid_o,
  output logic [DW-1:0]      r_data_o,
  output logic               req_o,
  output logic [AW-1:0]      add_o,
  output logic               wen_o,
  output logic [DW/8-1:0]    be_o,
  output logic [DW-1:0]      data_o,
  input  logic               gnt_i,
  input  logic               r_valid_i,
  input  logic [DW-1:0]      r_data_i,
  output logic               busy_o,
  output logic               err_o
);
  localparam int unsigned TW = (NR > 1) ? $clog2(NR) : 1;
  localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CW = $clog2(MAX_OUT + 1);
  localparam int unsigned SW = $clog2(STARVE_TH + 1);
  localparam int unsigned BW = DW / 8;

  logic [TW-1:0] rr_ptr, sel, cand, head_tag;
  logic [SW-1:0] starve_cnt [NR];
  logic [TW-1:0] tag_mem [MAX_OUT];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          err_q;
  logic [NR-1:0] eligible, starved;
  logic          full, empty, any_starved, found, push, pop;

  // Eligibility looks at the registered count, so a pop never frees a slot in its own cycle.
  assign full     = (count == CW'(MAX_OUT));
  assign empty    = (count == '0);
  assign eligible = req_i & {NR{~full}};
  assign req_o    = |eligible;

  always_comb begin
    starved = '0;
    for (int k = 0; k < NR; k++) begin
      starved[k] = eligible[k] & (starve_cnt[k] >= SW'(STARVE_TH));
    end
  end

  always_comb begin
    sel         = rr_ptr;
    cand        = rr_ptr;
    any_starved = 1'b0;
    found       = 1'b0;
    for (int k = 0; k < NR; k++) begin
      if (starved[k] && !any_starved) begin
        sel         = TW'(k);
        any_starved = 1'b1;
      end
    end
    if (!any_starved) begin
      for (int i = 0; i < NR; i++) begin
        cand = TW'((int'(rr_ptr) + i) % NR);
        if (!found && eligible[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  assign add_o  = req_o ? add_i[sel*AW +: AW] : '0;
  assign wen_o  = req_o & wen_i[sel];
  assign be_o   = req_o ? be_i[sel*BW +: BW] : '0;
  assign data_o = req_o ? data_i[sel*DW +: DW] : '0;

  assign push = req_o & gnt_i;

  always_comb begin
    gnt_o = '0;
    if (push) gnt_o[sel] = 1'b1;
  end

  // An empty FIFO with a same-cycle push hands the new tag straight to the response.
  assign pop      = r_valid_i & (~empty | push);
  assign head_tag = empty ? sel : tag_mem[rd_ptr];

  always_comb begin
    r_valid_o = '0;
    if (pop) r_valid_o[head_tag] = 1'b1;
  end

  assign r_data_o = r_data_i;
  assign busy_o   = ~empty;
  assign err_o    = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
      for (int k = 0; k < NR; k++) starve_cnt[k] <= '0;
    end else if (clear_i) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
      for (int k = 0; k < NR; k++) starve_cnt[k] <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(MAX_OUT - 1)) ? '0 : wr_ptr + 1'b1;
        rr_ptr <= (sel == TW'(NR - 1)) ? '0 : sel + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(MAX_OUT - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (r_valid_i && empty && !push) err_q <= 1'b1;
      for (int k = 0; k < NR; k++) begin
        if (!req_i[k] || (push && (sel == TW'(k)))) starve_cnt[k] <= '0;
        else if (starve_cnt[k] < SW'(STARVE_TH))    starve_cnt[k] <= starve_cnt[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clear_i) tag_mem[wr_ptr] <= sel;
  end

endmodule
